// File: rtl/axi_lite_slave_regs.sv
`default_nettype none
// ============================================================================
// Module      : axi_lite_slave_regs
// Description : AXI4-Lite slave register bank with byte-strobe writes and a
//               flat register image. Optional macro AXI_SLAVE_SLVERR_EN makes
//               out-of-range accesses answer SLVERR instead of OKAY.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_lite_slave_regs #(
  parameter int          NUM_REGS  = 8,
  parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
  input  logic                     ACLK,
  input  logic                     ARESET,
  input  logic                     AWVALID,
  output logic                     AWREADY,
  input  logic [31:0]              AWADDR,
  input  logic                     WVALID,
  output logic                     WREADY,
  input  logic [31:0]              WDATA,
  input  logic [3:0]               WSTRB,
  output logic                     BVALID,
  input  logic                     BREADY,
  output logic [1:0]               BRESP,
  input  logic                     ARVALID,
  output logic                     ARREADY,
  input  logic [31:0]              ARADDR,
  output logic                     RVALID,
  input  logic                     RREADY,
  output logic [31:0]              RDATA,
  output logic [1:0]               RRESP,
  output logic [32*NUM_REGS-1:0]   reg_bus,
  output logic [NUM_REGS-1:0]      wr_pulse
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

`ifdef AXI_SLAVE_SLVERR_EN
  localparam logic [1:0] c_OOR_RESP = 2'b10;
`else
  localparam logic [1:0] c_OOR_RESP = 2'b00;
`endif

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_HALF = 2'd1, W_RESP = 2'd2} wstate_t;
  typedef enum logic [0:0] {R_IDLE = 1'b0, R_DATA = 1'b1} rstate_t;

  // ---------------- write path ----------------
  wstate_t             r_wstate, w_wstate_nxt;
  logic                r_awready, w_awready_nxt;
  logic                r_wready, w_wready_nxt;
  logic                r_bvalid, w_bvalid_nxt;
  logic [1:0]          r_bresp, w_bresp_nxt;
  logic [29:0]         r_awidx;
  logic [31:0]         r_wdata;
  logic [3:0]          r_wstrb;
  logic [NUM_REGS-1:0] r_wr_pulse, w_wr_pulse_nxt;
  logic [31:0]         r_regs [NUM_REGS];

  logic                w_aw_hs, w_w_hs, w_commit, w_win_range;
  logic [29:0]         w_widx_full;
  logic [IDX_W-1:0]    w_widx;
  logic [31:0]         w_wdata_eff;
  logic [3:0]          w_wstrb_eff;

  assign w_aw_hs     = AWVALID && r_awready;
  assign w_w_hs      = WVALID && r_wready;
  // The half that handshakes this edge is taken live, the other from its latch.
  assign w_widx_full = w_aw_hs ? AWADDR[31:2] : r_awidx;
  assign w_wdata_eff = w_w_hs ? WDATA : r_wdata;
  assign w_wstrb_eff = w_w_hs ? WSTRB : r_wstrb;
  assign w_win_range = (w_widx_full < 30'(NUM_REGS));
  assign w_widx      = w_widx_full[IDX_W-1:0];

  always_comb begin
    w_wstate_nxt  = r_wstate;
    w_awready_nxt = r_awready;
    w_wready_nxt  = r_wready;
    w_bvalid_nxt  = r_bvalid;
    w_bresp_nxt   = r_bresp;
    w_commit      = 1'b0;
    case (r_wstate)
      W_IDLE: begin
        if (w_aw_hs && w_w_hs) begin
          w_commit = 1'b1;
        end else if (w_aw_hs) begin
          w_awready_nxt = 1'b0;
          w_wready_nxt  = 1'b1;
          w_wstate_nxt  = W_HALF;
        end else if (w_w_hs) begin
          w_awready_nxt = 1'b1;
          w_wready_nxt  = 1'b0;
          w_wstate_nxt  = W_HALF;
        end else begin
          w_awready_nxt = 1'b1;
          w_wready_nxt  = 1'b1;
        end
      end
      W_HALF: begin
        if (w_aw_hs || w_w_hs) w_commit = 1'b1;
      end
      W_RESP: begin
        if (BREADY) begin
          w_bvalid_nxt  = 1'b0;
          w_awready_nxt = 1'b1;
          w_wready_nxt  = 1'b1;
          w_wstate_nxt  = W_IDLE;
        end
      end
      default: w_wstate_nxt = W_IDLE;
    endcase
    if (w_commit) begin
      w_awready_nxt = 1'b0;
      w_wready_nxt  = 1'b0;
      w_bvalid_nxt  = 1'b1;
      w_bresp_nxt   = w_win_range ? 2'b00 : c_OOR_RESP;
      w_wstate_nxt  = W_RESP;
    end
  end

  // A pulse doubles as the register write enable; empty strobes give neither.
  always_comb begin
    w_wr_pulse_nxt = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (w_commit && w_win_range && (w_widx == IDX_W'(k)) && (|w_wstrb_eff))
        w_wr_pulse_nxt[k] = 1'b1;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_wstate   <= W_IDLE;
      r_awready  <= 1'b0;
      r_wready   <= 1'b0;
      r_bvalid   <= 1'b0;
      r_bresp    <= 2'b00;
      r_awidx    <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_wr_pulse <= '0;
      for (int k = 0; k < NUM_REGS; k++) r_regs[k] <= RESET_VAL;
    end else begin
      r_wstate   <= w_wstate_nxt;
      r_awready  <= w_awready_nxt;
      r_wready   <= w_wready_nxt;
      r_bvalid   <= w_bvalid_nxt;
      r_bresp    <= w_bresp_nxt;
      r_wr_pulse <= w_wr_pulse_nxt;
      if (w_aw_hs) r_awidx <= AWADDR[31:2];
      if (w_w_hs) begin
        r_wdata <= WDATA;
        r_wstrb <= WSTRB;
      end
      for (int k = 0; k < NUM_REGS; k++) begin
        for (int b = 0; b < 4; b++) begin
          if (w_wr_pulse_nxt[k] && w_wstrb_eff[b])
            r_regs[k][8*b +: 8] <= w_wdata_eff[8*b +: 8];
        end
      end
    end
  end

  // ---------------- read path ----------------
  rstate_t          r_rstate, w_rstate_nxt;
  logic             r_arready, w_arready_nxt;
  logic             r_rvalid, w_rvalid_nxt;
  logic [31:0]      r_rdata, w_rdata_nxt;
  logic [1:0]       r_rresp, w_rresp_nxt;
  logic             w_ar_hs, w_rin_range;
  logic [IDX_W-1:0] w_ridx;

  assign w_ar_hs     = ARVALID && r_arready;
  assign w_rin_range = (ARADDR[31:2] < 30'(NUM_REGS));
  assign w_ridx      = ARADDR[IDX_W+1:2];

  always_comb begin
    w_rstate_nxt  = r_rstate;
    w_arready_nxt = r_arready;
    w_rvalid_nxt  = r_rvalid;
    w_rdata_nxt   = r_rdata;
    w_rresp_nxt   = r_rresp;
    case (r_rstate)
      R_IDLE: begin
        if (w_ar_hs) begin
          w_arready_nxt = 1'b0;
          w_rvalid_nxt  = 1'b1;
          w_rdata_nxt   = w_rin_range ? r_regs[w_ridx] : 32'h0;
          w_rresp_nxt   = w_rin_range ? 2'b00 : c_OOR_RESP;
          w_rstate_nxt  = R_DATA;
        end else begin
          w_arready_nxt = 1'b1;
        end
      end
      R_DATA: begin
        if (RREADY) begin
          w_rvalid_nxt  = 1'b0;
          w_arready_nxt = 1'b1;
          w_rstate_nxt  = R_IDLE;
        end
      end
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= 32'h0;
      r_rresp   <= 2'b00;
    end else begin
      r_rstate  <= w_rstate_nxt;
      r_arready <= w_arready_nxt;
      r_rvalid  <= w_rvalid_nxt;
      r_rdata   <= w_rdata_nxt;
      r_rresp   <= w_rresp_nxt;
    end
  end

  // ---------------- outputs ----------------
  assign AWREADY  = r_awready;
  assign WREADY   = r_wready;
  assign BVALID   = r_bvalid;
  assign BRESP    = r_bresp;
  assign ARREADY  = r_arready;
  assign RVALID   = r_rvalid;
  assign RDATA    = r_rdata;
  assign RRESP    = r_rresp;
  assign wr_pulse = r_wr_pulse;

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_bus
    assign reg_bus[32*k +: 32] = r_regs[k];
  end

  // Byte-offset bits carry no meaning for word registers.
  wire w_unused_addr = ^{AWADDR[1:0], ARADDR[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_slave_regs.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_lite_slave_regs
// Description : Scoreboard bench for axi_lite_slave_regs (NUM_REGS = 8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_lite_slave_regs;

  localparam int NUM_REGS = 8;
`ifdef AXI_SLAVE_SLVERR_EN
  localparam logic [1:0] OOR_RESP = 2'b10;
`else
  localparam logic [1:0] OOR_RESP = 2'b00;
`endif

  logic ACLK, ARESET;
  logic AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic ARVALID, ARREADY, RVALID, RREADY;
  logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
  logic [3:0]  WSTRB;
  logic [1:0]  BRESP, RRESP;
  logic [32*NUM_REGS-1:0] reg_bus;
  logic [NUM_REGS-1:0]    wr_pulse;

  axi_lite_slave_regs #(.NUM_REGS(NUM_REGS), .RESET_VAL(32'h0)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR),
    .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP),
    .reg_bus(reg_bus), .wr_pulse(wr_pulse)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int cnt_cmp = 0;
  int cnt_err = 0;
  logic [1:0]          q_b[$];
  logic [33:0]         q_r[$];
  logic [31:0]         m_regs [NUM_REGS];
  logic [NUM_REGS-1:0] pulse_seen;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    cnt_cmp++;
    if (obs !== exp) begin
      cnt_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  function automatic logic [255:0] model_bus();
    logic [255:0] r;
    r = '0;
    for (int k = 0; k < NUM_REGS; k++) r[32*k +: 32] = m_regs[k];
    return r;
  endfunction

  // Responses are scored at the handshake; pulses are collected for later checks.
  always @(negedge ACLK) begin
    if (!ARESET) begin
      pulse_seen <= pulse_seen | wr_pulse;
      if (BVALID && BREADY) begin
        if (q_b.size() == 0) chk("b_unexpected", 1, 0);
        else chk("bresp", BRESP, q_b.pop_front());
      end
      if (RVALID && RREADY) begin
        if (q_r.size() == 0) chk("r_unexpected", 1, 0);
        else begin
          logic [33:0] e;
          e = q_r.pop_front();
          chk("rdata", RDATA, e[33:2]);
          chk("rresp", RRESP, e[1:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int n;
    logic in_rng;
    in_rng = (addr[31:2] < 30'(NUM_REGS));
    q_b.push_back(in_rng ? 2'b00 : OOR_RESP);
    AWADDR = addr; WDATA = data; WSTRB = strb; AWVALID = 1'b1; WVALID = 1'b1;
    n = 0;
    while (!(AWREADY && WREADY) && n < 20) begin tick(); n++; end
    if (n >= 20) chk("aw_w_timeout", 0, 1);
    tick();
    AWVALID = 1'b0; WVALID = 1'b0;
    if (in_rng) m_regs[int'(addr[31:2])] = merge(m_regs[int'(addr[31:2])], data, strb);
    n = 0;
    while (BVALID && n < 20) begin tick(); n++; end
    if (n >= 20) chk("b_timeout", 0, 1);
  endtask

  task automatic do_read(input logic [31:0] addr);
    int n;
    logic in_rng;
    in_rng = (addr[31:2] < 30'(NUM_REGS));
    q_r.push_back({in_rng ? m_regs[int'(addr[31:2])] : 32'h0, in_rng ? 2'b00 : OOR_RESP});
    ARADDR = addr; ARVALID = 1'b1;
    n = 0;
    while (!ARREADY && n < 20) begin tick(); n++; end
    if (n >= 20) chk("ar_timeout", 0, 1);
    tick();
    ARVALID = 1'b0;
    n = 0;
    while (RVALID && n < 20) begin tick(); n++; end
    if (n >= 20) chk("r_timeout", 0, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    ARESET = 1'b1; AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    BREADY = 1'b1; RREADY = 1'b1;
    AWADDR = '0; WDATA = '0; WSTRB = '0; ARADDR = '0;
    pulse_seen = '0;
    for (int k = 0; k < NUM_REGS; k++) m_regs[k] = 32'h0;
    repeat (3) tick();

    chk("rst_hs", {AWREADY, WREADY, ARREADY, BVALID, RVALID}, 5'b0);
    chk("rst_resp", {BRESP, RRESP, RDATA}, 36'h0);
    chk("rst_pulse", wr_pulse, 0);
    chk("rst_bus", reg_bus, model_bus());
    ARESET = 1'b0;
    tick();
    chk("rdy_after_rst", {AWREADY, WREADY, ARREADY}, 3'b111);

    // Same-cycle AW and W
    q_b.push_back(2'b00);
    AWADDR = 32'h04; WDATA = 32'hDEADBEEF; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1;
    tick();
    AWVALID = 1'b0; WVALID = 1'b0;
    m_regs[1] = 32'hDEADBEEF;
    chk("t1_bvalid", BVALID, 1);
    chk("t1_pulse", wr_pulse, 8'h02);
    chk("t1_rdy_low", {AWREADY, WREADY}, 2'b00);
    tick();
    chk("t1_bvalid_drop", BVALID, 0);
    chk("t1_pulse_drop", wr_pulse, 0);
    chk("t1_bus", reg_bus, model_bus());
    chk("t1_rdy_back", {AWREADY, WREADY}, 2'b11);

    // W leads AW by three cycles
    do_write(32'h08, 32'h11223344, 4'hF);
    q_b.push_back(2'b00);
    WDATA = 32'h000000AA; WSTRB = 4'h1; WVALID = 1'b1;
    tick();
    WVALID = 1'b0;
    chk("t2_w_only", {AWREADY, WREADY}, 2'b10);
    repeat (2) tick();
    chk("t2_wait", {WREADY, BVALID}, 2'b00);
    AWADDR = 32'h08; AWVALID = 1'b1;
    tick();
    AWVALID = 1'b0;
    m_regs[2] = merge(m_regs[2], 32'h000000AA, 4'h1);
    chk("t2_bvalid", BVALID, 1);
    chk("t2_pulse", wr_pulse, 8'h04);
    tick();
    chk("t2_bus", reg_bus, model_bus());

    // Back-pressured B channel
    BREADY = 1'b0;
    q_b.push_back(2'b00);
    AWADDR = 32'h0C; WDATA = 32'hCAFEF00D; WSTRB = 4'b1100; AWVALID = 1'b1; WVALID = 1'b1;
    tick();
    AWVALID = 1'b0; WVALID = 1'b0;
    m_regs[3] = merge(m_regs[3], 32'hCAFEF00D, 4'b1100);
    for (int i = 0; i < 5; i++) begin
      chk("t3_b_hold", {BVALID, BRESP}, 3'b100);
      chk("t3_rdy_low", {AWREADY, WREADY}, 2'b00);
      chk("t3_pulse", wr_pulse, (i == 0) ? 8'h08 : 8'h00);
      tick();
    end
    BREADY = 1'b1;
    tick();
    chk("t3_after_b", {BVALID, AWREADY, WREADY}, 3'b011);
    chk("t3_bus", reg_bus, model_bus());

    // Back-pressured R channel
    RREADY = 1'b0;
    q_r.push_back({32'hDEADBEEF, 2'b00});
    ARADDR = 32'h04; ARVALID = 1'b1;
    tick();
    ARVALID = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t4_r_hold", {RVALID, ARREADY, RDATA}, {2'b10, 32'hDEADBEEF});
      tick();
    end
    RREADY = 1'b1;
    tick();
    chk("t4_after_r", {RVALID, ARREADY}, 2'b01);

    // Read and write of the same register on one edge
    do_write(32'h00, 32'h1, 4'hF);
    chk("t5_rdy", {AWREADY, WREADY, ARREADY}, 3'b111);
    q_r.push_back({32'h1, 2'b00});
    q_b.push_back(2'b00);
    AWADDR = 32'h00; WDATA = 32'h2; WSTRB = 4'hF; ARADDR = 32'h00;
    AWVALID = 1'b1; WVALID = 1'b1; ARVALID = 1'b1;
    tick();
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    m_regs[0] = 32'h2;
    tick();
    do_read(32'h00);

    // Out-of-range accesses
    pulse_seen = '0;
    do_write(32'h40, 32'h55555555, 4'hF);
    chk("t6_no_pulse", pulse_seen, 0);
    chk("t6_bus", reg_bus, model_bus());
    do_read(32'h40);

    // Empty strobe
    pulse_seen = '0;
    do_write(32'h10, 32'hFFFFFFFF, 4'h0);
    chk("t7_no_pulse", pulse_seen, 0);
    chk("t7_bus", reg_bus, model_bus());

    // Last register, byte-offset bits set
    pulse_seen = '0;
    do_write(32'h1F, 32'hA5A55A5A, 4'b0110);
    chk("t8_pulse", pulse_seen, 8'h80);
    chk("t8_bus", reg_bus, model_bus());
    do_read(32'h1C);

    repeat (3) tick();
    chk("q_b_empty", q_b.size(), 0);
    chk("q_r_empty", q_r.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cnt_cmp, cnt_err);
    $finish;
  end

endmodule
`default_nettype wire
